// File: rtl/commit_recovery_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : commit_recovery_sequencer
// Description : Sequences pipeline recovery after the commit stage reports a
//               mis-speculation, trap or fault. Latches the request, drives
//               the pipeline phase, optionally waits for committed stores to
//               drain, walks the active-list flush in FLUSH_WIDTH-entry
//               chunks, then issues one refetch request and waits for its ack.
//
// Ports       : clk, rst                  clock, synchronous active-high reset
//               exceptionDetected         recovery request (sampled in IDLE)
//               refetchTypeIn/recoveryCauseIn  request attributes to latch
//               needDrain                 wait for committed-store queue first
//               flushNum                  active-list entries to flush
//               storeDrained              committed-store queue empty
//               refetchAck                fetch unit accepted the refetch
//               phase                     0 = COMMIT, 1 = RECOVER
//               unableToStartRecovery     busy, new request cannot start
//               flushValid/flushCount     per-cycle flush command
//               refetchReq                refetch request, held until ack
//               refetchType/recoveryCause latched request attributes
//               perfRecoveryCount/Cycles  (RSD_RECOVERY_PERF_COUNTER_EN only)
//
// Config      : RSD_RECOVERY_PERF_COUNTER_EN adds saturating 32-bit counters
//               of recoveries started and of cycles spent recovering.
//
// Revision    : 1.0 - initial release
// ============================================================================
module commit_recovery_sequencer #(
    parameter int AL_COUNT_WIDTH = 7,
    parameter int FLUSH_WIDTH    = 4,
    parameter int REFETCH_WIDTH  = 3,
    parameter int CAUSE_WIDTH    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          exceptionDetected,
    input  logic [REFETCH_WIDTH-1:0]      refetchTypeIn,
    input  logic [CAUSE_WIDTH-1:0]        recoveryCauseIn,
    input  logic                          needDrain,
    input  logic [AL_COUNT_WIDTH-1:0]     flushNum,
    input  logic                          storeDrained,
    input  logic                          refetchAck,
    output logic                          phase,
    output logic                          unableToStartRecovery,
    output logic                          flushValid,
    output logic [$clog2(FLUSH_WIDTH):0]  flushCount,
    output logic                          refetchReq,
    output logic [REFETCH_WIDTH-1:0]      refetchType,
    output logic [CAUSE_WIDTH-1:0]        recoveryCause
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    ,
    output logic [31:0]                   perfRecoveryCount,
    output logic [31:0]                   perfRecoveryCycles
`endif
);

    localparam int c_countWidth = $clog2(FLUSH_WIDTH) + 1;
    localparam logic [AL_COUNT_WIDTH-1:0] c_flushWidthAl  = AL_COUNT_WIDTH'(FLUSH_WIDTH);
    localparam logic [c_countWidth-1:0]   c_flushWidthCnt = c_countWidth'(FLUSH_WIDTH);

    localparam logic [1:0] c_stIdle    = 2'd0;
    localparam logic [1:0] c_stDrain   = 2'd1;
    localparam logic [1:0] c_stFlush   = 2'd2;
    localparam logic [1:0] c_stRefetch = 2'd3;

    logic [1:0]                r_state;
    logic [AL_COUNT_WIDTH-1:0] r_remaining;
    logic                      r_phase;
    logic                      r_unable;
    logic                      r_flushValid;
    logic [c_countWidth-1:0]   r_flushCount;
    logic                      r_refetchReq;
    logic [REFETCH_WIDTH-1:0]  r_refetchType;
    logic [CAUSE_WIDTH-1:0]    r_recoveryCause;
    logic [10:0]               r_busyCycles;

    logic [1:0]                w_nextState;
    logic                      w_latch;
    logic [AL_COUNT_WIDTH-1:0] w_flushSrc;
    logic [c_countWidth-1:0]   w_chunk;

    // Next-state logic. w_flushSrc is the number of entries still owed at the
    // edge that moves into (or stays in) FLUSH: the fresh request size when
    // leaving IDLE, otherwise the latched remainder.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_flushSrc  = r_remaining;
        case (r_state)
            c_stIdle: begin
                if (exceptionDetected) begin
                    w_latch    = 1'b1;
                    w_flushSrc = flushNum;
                    if (needDrain)
                        w_nextState = c_stDrain;
                    else if (flushNum != '0)
                        w_nextState = c_stFlush;
                    else
                        w_nextState = c_stRefetch;
                end
            end
            c_stDrain: begin
                if (storeDrained)
                    w_nextState = (r_remaining != '0) ? c_stFlush : c_stRefetch;
            end
            c_stFlush: begin
                // The remainder already accounts for the chunk shown this
                // cycle, so zero means this was the last flush cycle.
                if (r_remaining == '0)
                    w_nextState = c_stRefetch;
            end
            c_stRefetch: begin
                if (refetchAck)
                    w_nextState = c_stIdle;
            end
            default: w_nextState = c_stIdle;
        endcase
    end

    // min(owed, FLUSH_WIDTH); below FLUSH_WIDTH the value fits the count width.
    always_comb begin
        w_chunk = (w_flushSrc >= c_flushWidthAl) ? c_flushWidthCnt
                                                 : w_flushSrc[c_countWidth-1:0];
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_stIdle;
            r_remaining     <= '0;
            r_phase         <= 1'b0;
            r_unable        <= 1'b0;
            r_flushValid    <= 1'b0;
            r_flushCount    <= '0;
            r_refetchReq    <= 1'b0;
            r_refetchType   <= '0;
            r_recoveryCause <= '0;
        end else begin
            r_state      <= w_nextState;
            r_phase      <= (w_nextState != c_stIdle);
            r_unable     <= (w_nextState != c_stIdle);
            r_flushValid <= (w_nextState == c_stFlush);
            r_flushCount <= (w_nextState == c_stFlush) ? w_chunk : '0;
            r_refetchReq <= (w_nextState == c_stRefetch);
            if (w_nextState == c_stFlush)
                r_remaining <= w_flushSrc - AL_COUNT_WIDTH'(w_chunk);
            else if (w_latch)
                r_remaining <= flushNum;
            if (w_latch) begin
                r_refetchType   <= refetchTypeIn;
                r_recoveryCause <= recoveryCauseIn;
            end
        end
    end

    // Watchdog on time spent recovering.
    always_ff @(posedge clk) begin
        if (rst || r_state == c_stIdle)
            r_busyCycles <= '0;
        else if (r_busyCycles != '1)
            r_busyCycles <= r_busyCycles + 11'd1;
    end

    a_recoveryBounded: assert property (@(posedge clk) disable iff (rst)
        r_busyCycles <= 11'd1000);

    assign phase                 = r_phase;
    assign unableToStartRecovery = r_unable;
    assign flushValid            = r_flushValid;
    assign flushCount            = r_flushCount;
    assign refetchReq            = r_refetchReq;
    assign refetchType           = r_refetchType;
    assign recoveryCause         = r_recoveryCause;

`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    logic [31:0] r_perfCount;
    logic [31:0] r_perfCycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfCount  <= '0;
            r_perfCycles <= '0;
        end else begin
            if (r_state == c_stIdle && w_nextState != c_stIdle && r_perfCount != '1)
                r_perfCount <= r_perfCount + 32'd1;
            if (r_state != c_stIdle && r_perfCycles != '1)
                r_perfCycles <= r_perfCycles + 32'd1;
        end
    end

    assign perfRecoveryCount  = r_perfCount;
    assign perfRecoveryCycles = r_perfCycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_recovery_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_recovery_sequencer
// Description : Self-checking bench for commit_recovery_sequencer. A table of
//               per-cycle input/expected-output records drives the main
//               recovery flows; short hand-written sequences cover draining,
//               reset during recovery and the optional performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_recovery_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       exceptionDetected = 1'b0;
    logic [2:0] refetchTypeIn = '0;
    logic [4:0] recoveryCauseIn = '0;
    logic       needDrain = 1'b0;
    logic [6:0] flushNum = '0;
    logic       storeDrained = 1'b0;
    logic       refetchAck = 1'b0;
    logic       phase;
    logic       unableToStartRecovery;
    logic       flushValid;
    logic [2:0] flushCount;
    logic       refetchReq;
    logic [2:0] refetchType;
    logic [4:0] recoveryCause;
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
    logic [31:0] perfRecoveryCount;
    logic [31:0] perfRecoveryCycles;
`endif

    commit_recovery_sequencer #(
        .AL_COUNT_WIDTH (7),
        .FLUSH_WIDTH    (4),
        .REFETCH_WIDTH  (3),
        .CAUSE_WIDTH    (5)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .exceptionDetected     (exceptionDetected),
        .refetchTypeIn         (refetchTypeIn),
        .recoveryCauseIn       (recoveryCauseIn),
        .needDrain             (needDrain),
        .flushNum              (flushNum),
        .storeDrained          (storeDrained),
        .refetchAck            (refetchAck),
        .phase                 (phase),
        .unableToStartRecovery (unableToStartRecovery),
        .flushValid            (flushValid),
        .flushCount            (flushCount),
        .refetchReq            (refetchReq),
        .refetchType           (refetchType),
        .recoveryCause         (recoveryCause)
`ifdef RSD_RECOVERY_PERF_COUNTER_EN
        ,
        .perfRecoveryCount     (perfRecoveryCount),
        .perfRecoveryCycles    (perfRecoveryCycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        exc;
        logic [2:0]  rt;
        logic [4:0]  cs;
        logic        nd;
        logic [6:0]  fn;
        logic        sd;
        logic        ack;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   nChecks = 0;
    int   nPass   = 0;

    // {phase, unable, flushValid, flushCount, refetchReq, refetchType, cause}
    function automatic logic [14:0] e(input logic ph, input logic fv, input logic [2:0] fc,
                                      input logic rr, input logic [2:0] rt, input logic [4:0] cs);
        return {ph, ph, fv, fc, rr, rt, cs};
    endfunction

    function automatic logic [14:0] obs();
        return {phase, unableToStartRecovery, flushValid, flushCount, refetchReq,
                refetchType, recoveryCause};
    endfunction

    task automatic add(input logic r, input logic x, input logic [2:0] rt, input logic [4:0] cs,
                       input logic nd, input logic [6:0] fn, input logic sd, input logic ack,
                       input logic eph, input logic efv, input logic [2:0] efc,
                       input logic err, input logic [2:0] ert, input logic [4:0] ecs);
        vec_t v;
        v.rst = r; v.exc = x; v.rt = rt; v.cs = cs; v.nd = nd; v.fn = fn; v.sd = sd;
        v.ack = ack;
        v.exp = e(eph, efv, efc, err, ert, ecs);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst exc rt cs nd fn sd ack | ph fv fc rr rt cs
        add(1, 1, 5,  9, 0, 10, 0, 0,   0, 0, 0, 0, 0,  0);  // reset ignores request
        add(1, 1, 5,  9, 0, 10, 0, 0,   0, 0, 0, 0, 0,  0);
        add(0, 1, 3,  7, 0, 10, 0, 0,   1, 1, 4, 0, 3,  7);  // flush 10: 4,4,2
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 1, 4, 0, 3,  7);
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 1, 2, 0, 3,  7);
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 0, 1, 3,  7);  // refetch
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 0, 1, 3,  7);
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 0, 1, 3,  7);
        add(0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 3,  7);  // ack -> idle
        add(0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 3,  7);  // stray ack ignored
        add(0, 1, 6,  1, 0,  0, 0, 0,   1, 0, 0, 1, 6,  1);  // zero flush
        add(0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 6,  1);
        add(0, 1, 2, 31, 0,  8, 0, 0,   1, 1, 4, 0, 2, 31);  // flush 8: 4,4
        add(0, 1, 7,  3, 0,  0, 0, 0,   1, 1, 4, 0, 2, 31);  // busy request ignored
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 0, 1, 2, 31);
        add(0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 2, 31);
        add(0, 1, 1,  2, 0,  3, 0, 0,   1, 1, 3, 0, 1,  2);  // single partial chunk
        add(0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 0, 1, 1,  2);
        add(0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 1,  2);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            rst               = vecs[i].rst;
            exceptionDetected = vecs[i].exc;
            refetchTypeIn     = vecs[i].rt;
            recoveryCauseIn   = vecs[i].cs;
            needDrain         = vecs[i].nd;
            flushNum          = vecs[i].fn;
            storeDrained      = vecs[i].sd;
            refetchAck        = vecs[i].ack;
            tick();
            check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end

        // Drain: storeDrained low for 5 cycles holds off the flush.
        rst = 0; refetchAck = 0;
        exceptionDetected = 1; needDrain = 1; flushNum = 7'd5; storeDrained = 0;
        refetchTypeIn = 3'd4; recoveryCauseIn = 5'd10;
        tick();
        check("drainEnter", 32'(obs()), 32'(e(1, 0, 0, 0, 4, 10)));
        exceptionDetected = 0; needDrain = 0; flushNum = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("drainHold%0d", i), 32'(obs()), 32'(e(1, 0, 0, 0, 4, 10)));
        end
        storeDrained = 1;
        tick();
        check("drainFlush0", 32'(obs()), 32'(e(1, 1, 4, 0, 4, 10)));
        storeDrained = 0;
        tick();
        check("drainFlush1", 32'(obs()), 32'(e(1, 1, 1, 0, 4, 10)));
        tick();
        check("drainRefetch", 32'(obs()), 32'(e(1, 0, 0, 1, 4, 10)));
        refetchAck = 1;
        tick();
        check("drainIdle", 32'(obs()), 32'(e(0, 0, 0, 0, 4, 10)));
        refetchAck = 0;

        // Drain already complete on entry still spends one cycle draining.
        exceptionDetected = 1; needDrain = 1; flushNum = '0; storeDrained = 1;
        refetchTypeIn = 3'd1; recoveryCauseIn = 5'd1;
        tick();
        check("drainFastEnter", 32'(obs()), 32'(e(1, 0, 0, 0, 1, 1)));
        exceptionDetected = 0; needDrain = 0;
        tick();
        check("drainFastRefetch", 32'(obs()), 32'(e(1, 0, 0, 1, 1, 1)));
        refetchAck = 1; storeDrained = 0;
        tick();
        check("drainFastIdle", 32'(obs()), 32'(e(0, 0, 0, 0, 1, 1)));
        refetchAck = 0;

        // Reset while a refetch is pending.
        exceptionDetected = 1; flushNum = '0; refetchTypeIn = 3'd5; recoveryCauseIn = 5'd5;
        tick();
        check("midRefetch", 32'(obs()), 32'(e(1, 0, 0, 1, 5, 5)));
        exceptionDetected = 0; rst = 1;
        tick();
        check("midReset", 32'(obs()), 32'(e(0, 0, 0, 0, 0, 0)));
        rst = 0;

`ifdef RSD_RECOVERY_PERF_COUNTER_EN
        check("perfCountReset", perfRecoveryCount, 32'd0);
        for (int i = 0; i < 3; i++) begin
            exceptionDetected = 1; flushNum = '0;
            tick();
            exceptionDetected = 0; refetchAck = 1;
            tick();
            refetchAck = 0;
        end
        check("perfCount", perfRecoveryCount, 32'd3);
        check("perfCycles", perfRecoveryCycles, 32'd3);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
